adc_frame_collector: RTL and testbench

- Reader end of the ADC sample stream (adc_data / adc_data_valid), sitting between the ADC sampler and the analysis core.
- On start, captures FRAME_LEN consecutive samples and converts each from offset-binary to two's complement.
- Buffers the frame in on-chip RAM, then streams it out on a valid/ready/last interface for the FFT/fingerprint stage.
- The input has no backpressure, so samples arriving while a frame drains are dropped and counted.

---
 rtl/shazam_pkg.sv | 16 +
 rtl/adc_frame_collector_if.sv | 22 ++
 rtl/frame_ram.sv | 22 ++
 rtl/adc_frame_collector.sv | 130 +++++++++++++
 tb/tb_adc_frame_collector.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shazam_pkg.sv
// Shared constants and types for the ADC capture path.
// ADC sample width, mid-scale code, default frame length, overrun counter width, collector states.
package shazam_pkg;

    localparam int ADC_W             = 12;
    localparam logic [ADC_W-1:0] ADC_MIDSCALE = 12'h800;
    localparam int FRAME_LEN_DEFAULT = 256;
    localparam int OVERRUN_W         = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_e;

endpackage

// File: rtl/adc_frame_collector_if.sv
// Sample-in strobe bus plus frame-out valid/ready/last stream.
// master = the surroundings (sampler + consumer); slave = the collector.
interface adc_frame_collector_if #(
    parameter int DATA_W = shazam_pkg::ADC_W
);
    logic [DATA_W-1:0] adc_data;
    logic              adc_data_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output adc_data, adc_data_valid, out_ready,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  adc_data, adc_data_valid, out_ready,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Read data appears one cycle after the address; no reset on the array so block RAM is inferred.
module frame_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/adc_frame_collector.sv
// Captures FRAME_LEN offset-binary ADC samples as two's complement, then streams them out with last.
// Input never stalls: samples seen while draining are dropped and counted. ADC_FRAME_DECIM2_EN averages input pairs.
module adc_frame_collector
    import shazam_pkg::*;
#(
    parameter int DATA_W    = ADC_W,
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
    parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    adc_frame_collector_if.slave bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic [OVERRUN_W-1:0] overrun_cnt
);
    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_CAPTURE = CAPTURE;
    localparam logic [1:0] S_DRAIN   = DRAIN;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic              we;
    logic [DATA_W-1:0] cap_sample;
    logic [DATA_W-1:0] wr_dat;
    logic [DATA_W-1:0] rd_dat;
    logic              beat_acc;

    function automatic logic [DATA_W-1:0] ob_to_tc(input logic [DATA_W-1:0] s);
        return {~s[DATA_W-1], s[DATA_W-2:0]};
    endfunction

`ifdef ADC_FRAME_DECIM2_EN
    logic              pair_phase;
    logic [DATA_W-1:0] pair_first;
    logic [DATA_W:0]   pair_sum;

    assign pair_sum   = {1'b0, pair_first} + {1'b0, bus.adc_data};
    assign cap_sample = pair_sum[DATA_W:1];
    assign we         = (state == S_CAPTURE) && bus.adc_data_valid && pair_phase;

    // Phase is forced to 0 outside CAPTURE so every frame starts on a pair boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pair_phase <= 1'b0;
            pair_first <= '0;
        end else if (state != S_CAPTURE) begin
            pair_phase <= 1'b0;
        end else if (bus.adc_data_valid) begin
            pair_phase <= ~pair_phase;
            if (!pair_phase) begin
                pair_first <= bus.adc_data;
            end
        end
    end
`else
    assign cap_sample = bus.adc_data;
    assign we         = (state == S_CAPTURE) && bus.adc_data_valid;
`endif

    assign wr_dat = ob_to_tc(cap_sample);

    // Read address runs one beat ahead on acceptance, so the registered RAM output is
    // always the presented beat and holds still while the consumer stalls.
    assign beat_acc = bus.out_valid && bus.out_ready;
    assign rd_addr  = (state == S_DRAIN) ? rd_idx + ADDR_W'(beat_acc) : '0;

    frame_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_frame_ram (
        .clk  (clk),
        .we   (we),
        .waddr(wr_ptr),
        .wdata(wr_dat),
        .raddr(rd_addr),
        .rdata(rd_dat)
    );

    assign bus.out_valid = (state == S_DRAIN);
    assign bus.out_data  = bus.out_valid ? rd_dat : '0;
    assign bus.out_last  = bus.out_valid && (rd_idx == LAST_IDX);
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_idx      <= '0;
            frame_done  <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_CAPTURE;
                        wr_ptr <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (we) begin
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                        if (wr_ptr == LAST_IDX) begin
                            state  <= S_DRAIN;
                            rd_idx <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.adc_data_valid && (overrun_cnt != '1)) begin
                        overrun_cnt <= overrun_cnt + OVERRUN_W'(1);
                    end
                    if (beat_acc) begin
                        rd_idx <= rd_idx + ADDR_W'(1);
                        if (rd_idx == LAST_IDX) begin
                            state      <= S_IDLE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_frame_collector.sv
// Directed bench for adc_frame_collector: capture, drain with stalls, overrun, back-to-back, async reset.
module tb_adc_frame_collector;
    import shazam_pkg::*;

    localparam int FL = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic [15:0] overrun_cnt;

    int compared   = 0;
    int mismatched = 0;

    adc_frame_collector_if #(.DATA_W(12)) bus ();

    adc_frame_collector #(
        .DATA_W   (12),
        .FRAME_LEN(FL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus.slave),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun_cnt(overrun_cnt)
    );

    always #10 clk = ~clk;

    function automatic logic [11:0] pat(input int i, input int seed);
        if (seed == 0 && i < 4) begin
            case (i)
                0: return 12'h800;
                1: return 12'hFFF;
                2: return 12'h000;
                default: return 12'h801;
            endcase
        end
        return 12'((i * 37 + seed * 101) & 'hFFF);
    endfunction

    // Seed 99 is the decimation frame whose first two beats come from unequal pairs.
    function automatic logic [11:0] exp_val(input int i, input int seed);
        if (seed == 99 && i == 0) return 12'h001;
        if (seed == 99 && i == 1) return 12'h7FE;
        return pat(i, seed) ^ ADC_MIDSCALE;
    endfunction

    task automatic feed_sample(input logic [11:0] v);
        bus.adc_data_valid = 1'b1;
        bus.adc_data       = v;
        @(negedge clk);
`ifdef ADC_FRAME_DECIM2_EN
        @(negedge clk);
`endif
    endtask

    task automatic feed_frame(input int seed);
        for (int i = 0; i < FL; i++) feed_sample(pat(i, seed));
        bus.adc_data_valid = 1'b0;
    endtask

    // A junk valid rides along with the start edge and must not be captured.
    task automatic start_capture(input bit hold);
        start              = 1'b1;
        bus.adc_data_valid = 1'b1;
        bus.adc_data       = 12'h123;
        @(negedge clk);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL start_busy busy=%b want 1", busy);
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic drain_check(input int seed, input bit rnd, input int inject, input string name);
        int idx = 0;
        int cyc = 0;
        int w = 0;
        int inj;
        bit stalled = 1'b0;
        bit rdy;
        logic [11:0] pd = '0;
        inj = inject;
        while (bus.out_valid !== 1'b1 && w < 2) begin
            @(negedge clk);
            w++;
        end
        compared++;
        if (bus.out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL %s valid_latency out_valid=%b want 1", name, bus.out_valid);
            return;
        end
        while (idx < FL && cyc < 4 * FL) begin
            compared++;
            if (bus.out_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL %s bubble beat %0d out_valid=%b want 1", name, idx, bus.out_valid);
            end
            compared++;
            if (bus.out_data !== exp_val(idx, seed)) begin
                mismatched++;
                $display("FAIL %s data beat %0d got %h want %h", name, idx, bus.out_data, exp_val(idx, seed));
            end
            compared++;
            if (bus.out_last !== 1'(idx == FL - 1)) begin
                mismatched++;
                $display("FAIL %s last beat %0d got %b want %b", name, idx, bus.out_last, idx == FL - 1);
            end
            if (stalled) begin
                compared++;
                if (bus.out_data !== pd) begin
                    mismatched++;
                    $display("FAIL %s stall_hold beat %0d got %h want %h", name, idx, bus.out_data, pd);
                end
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready      = rdy;
            bus.adc_data_valid = (inj > 0);
            if (inj > 0) inj--;
            stalled = !rdy;
            pd      = bus.out_data;
            if (rdy) idx++;
            @(negedge clk);
            cyc++;
        end
        bus.adc_data_valid = 1'b0;
        bus.out_ready      = 1'b0;
        compared++;
        if (idx != FL) begin
            mismatched++;
            $display("FAIL %s beat_count got %0d want %0d", name, idx, FL);
        end
        compared++;
        if (bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL %s valid_after_last got %b want 0", name, bus.out_valid);
        end
        compared++;
        if (frame_done !== 1'b1) begin
            mismatched++;
            $display("FAIL %s frame_done got %b want 1", name, frame_done);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s busy_after_last got %b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        bus.adc_data = '0;
        bus.adc_data_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        compared++; if (busy !== 1'b0)        begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++; if (frame_done !== 1'b0)  begin mismatched++; $display("FAIL reset_done got %b want 0", frame_done); end
        compared++; if (overrun_cnt !== 16'h0) begin mismatched++; $display("FAIL reset_overrun got %h want 0", overrun_cnt); end
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        compared++; if (bus.out_data !== 12'h0) begin mismatched++; $display("FAIL reset_data got %h want 0", bus.out_data); end
        compared++; if (bus.out_last !== 1'b0)  begin mismatched++; $display("FAIL reset_last got %b want 0", bus.out_last); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        start_capture(1'b0);
        feed_frame(0);
        drain_check(0, 1'b0, 0, "basic");
        @(negedge clk);
        compared++;
        if (frame_done !== 1'b0) begin
            mismatched++;
            $display("FAIL done_single_pulse got %b want 0", frame_done);
        end
    endtask

    task automatic test_random_ready();
        start_capture(1'b0);
        feed_frame(3);
        drain_check(3, 1'b1, 0, "random_ready");
        @(negedge clk);
    endtask

    task automatic test_overrun();
        start_capture(1'b0);
        feed_frame(7);
        drain_check(7, 1'b0, 10, "overrun10");
        compared++;
        if (overrun_cnt !== 16'd10) begin
            mismatched++;
            $display("FAIL overrun_10 got %0d want 10", overrun_cnt);
        end
        @(negedge clk);
        start_capture(1'b0);
        feed_frame(8);
        bus.out_ready      = 1'b0;
        bus.adc_data_valid = 1'b1;
        repeat (70000) @(negedge clk);
        bus.adc_data_valid = 1'b0;
        compared++;
        if (overrun_cnt !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL overrun_sat got %h want ffff", overrun_cnt);
        end
        compared++;
        if (bus.out_data !== exp_val(0, 8)) begin
            mismatched++;
            $display("FAIL overrun_hold got %h want %h", bus.out_data, exp_val(0, 8));
        end
        drain_check(8, 1'b0, 0, "after_sat");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        start_capture(1'b1);
        feed_frame(5);
        drain_check(5, 1'b0, 0, "b2b_first");
        bus.adc_data_valid = 1'b1;
        bus.adc_data       = 12'h456;
        @(negedge clk);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_restart busy=%b want 1", busy);
        end
        compared++;
        if (frame_done !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_done_clear got %b want 0", frame_done);
        end
        feed_frame(6);
        start = 1'b0;
        drain_check(6, 1'b0, 0, "b2b_second");
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        start_capture(1'b0);
        for (int i = 0; i < 100; i++) feed_sample(pat(i, 11));
        reset = 1'b0;
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy got %b want 0", busy); end
        compared++; if (overrun_cnt !== 16'h0) begin mismatched++; $display("FAIL midrst_overrun got %h want 0", overrun_cnt); end
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
        compared++; if (bus.out_data !== 12'h0) begin mismatched++; $display("FAIL midrst_data got %h want 0", bus.out_data); end
        @(negedge clk);
        bus.adc_data_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        start_capture(1'b0);
        feed_frame(12);
        drain_check(12, 1'b0, 0, "after_reset");
        @(negedge clk);
    endtask

`ifdef ADC_FRAME_DECIM2_EN
    task automatic test_decim();
        logic [11:0] v;
        start_capture(1'b0);
        for (int k = 0; k < 2 * FL; k++) begin
            case (k)
                0: v = 12'h800;
                1: v = 12'h802;
                2: v = 12'hFFF;
                3: v = 12'hFFD;
                default: v = pat(k / 2, 99);
            endcase
            bus.adc_data_valid = 1'b1;
            bus.adc_data       = v;
            @(negedge clk);
            if (k == 2 * FL - 2) begin
                compared++;
                if (bus.out_valid !== 1'b0) begin
                    mismatched++;
                    $display("FAIL decim_511 out_valid=%b want 0", bus.out_valid);
                end
            end
        end
        bus.adc_data_valid = 1'b0;
        drain_check(99, 1'b0, 0, "decim");
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_random_ready();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef ADC_FRAME_DECIM2_EN
        test_decim();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
